// File: rtl/sig16b_to_double_pkg.sv
// Shared constants and state encoding for the sign-magnitude to binary64 converter.
package sig16b_to_double_pkg;

    localparam int DOUBLE_BIAS = 1023;
    localparam int EXP_INIT    = 1037;
    localparam int SIG16B_W    = 16;
    localparam int DOUBLE_W    = 64;
    localparam int MANT_W      = 52;
    localparam int EXP_W       = 11;
    localparam int MAG_W       = SIG16B_W - 1;

    typedef enum logic {
        IDLE = 1'b0,
        NORM = 1'b1
    } state_t;

endpackage

// File: rtl/sig16b_to_double.sv
// Converts a 16-bit sign-magnitude integer sample into an IEEE-754 binary64
// value by iteratively shifting the magnitude until its leading one reaches
// bit 14, decrementing the exponent on each shift.
// Optional feature macro: SIG16B_TO_DOUBLE_OVERRUN_EN adds a sticky overrun flag
// that records capture requests dropped while a conversion is in progress.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for a capture slot (counter==0 with enable)
// NORM  | normalizing mag_q; emits the result once bit 14 is set or mag is 0
module sig16b_to_double
    import sig16b_to_double_pkg::*;
(
    input  logic                 clk_operation,
    input  logic                 rst,
    input  logic [12:0]          sampling_cycle_counter,
    input  logic                 enable,
    input  logic [SIG16B_W-1:0]  sig16b,
    output logic [DOUBLE_W-1:0]  double,
    output logic                 double_valid,
    output logic                 busy
`ifdef SIG16B_TO_DOUBLE_OVERRUN_EN
    ,
    output logic                 overrun
`endif
);

    state_t              state_q, state_d;
    logic                sign_q, sign_d;
    logic [MAG_W-1:0]    mag_q, mag_d;
    logic [EXP_W-1:0]    exp_q, exp_d;
    logic [DOUBLE_W-1:0] double_q, double_d;
    logic                valid_q, valid_d;
    logic                capture_req;

    assign capture_req = (sampling_cycle_counter == 13'd0) && enable;

    // Next-state: capture in IDLE, then shift-normalize until the leading one sits at bit 14.
    always_comb begin
        state_d  = state_q;
        sign_d   = sign_q;
        mag_d    = mag_q;
        exp_d    = exp_q;
        double_d = double_q;
        valid_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (capture_req) begin
                    sign_d  = sig16b[SIG16B_W-1];
                    mag_d   = sig16b[MAG_W-1:0];
                    exp_d   = EXP_W'(EXP_INIT);
                    state_d = NORM;
                end
            end
            NORM: begin
                if (mag_q == '0) begin
                    // Zero has no leading one; the sign is dropped so -0 reports as +0.
                    double_d = '0;
                    valid_d  = 1'b1;
                    state_d  = IDLE;
                end else if (mag_q[MAG_W-1]) begin
                    // Bit 14 is the implicit one; the remaining 14 bits fill the top of the mantissa.
                    double_d = {sign_q, exp_q, mag_q[MAG_W-2:0], {(MANT_W-(MAG_W-1)){1'b0}}};
                    valid_d  = 1'b1;
                    state_d  = IDLE;
                end else begin
                    mag_d = mag_q << 1;
                    exp_d = exp_q - EXP_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset; reset aborts any conversion.
    always_ff @(posedge clk_operation) begin
        if (rst) begin
            state_q  <= IDLE;
            sign_q   <= 1'b0;
            mag_q    <= '0;
            exp_q    <= '0;
            double_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            sign_q   <= sign_d;
            mag_q    <= mag_d;
            exp_q    <= exp_d;
            double_q <= double_d;
            valid_q  <= valid_d;
        end
    end

`ifdef SIG16B_TO_DOUBLE_OVERRUN_EN
    logic overrun_q, overrun_d;

    // Overrun is sticky: any capture request seen mid-conversion sets it until reset.
    always_comb begin
        overrun_d = overrun_q;
        if (capture_req && (state_q == NORM)) begin
            overrun_d = 1'b1;
        end
    end

    // Overrun register, cleared only by reset.
    always_ff @(posedge clk_operation) begin
        if (rst) begin
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= overrun_d;
        end
    end

    assign overrun = overrun_q;
`endif

    assign double       = double_q;
    assign double_valid = valid_q;
    assign busy         = (state_q == NORM);

endmodule

// File: tb/tb_sig16b_to_double.sv
// Scoreboard bench for sig16b_to_double: each capture pushes the independently
// modelled binary64 value and its expected arrival edge; a monitor pops on valid.
module tb_sig16b_to_double;
    import sig16b_to_double_pkg::*;

    logic        clk_operation = 1'b0;
    logic        rst = 1'b1;
    logic [12:0] sampling_cycle_counter = 13'd7;
    logic        enable = 1'b0;
    logic [15:0] sig16b = 16'h0;
    logic [63:0] double;
    logic        double_valid;
    logic        busy;
`ifdef SIG16B_TO_DOUBLE_OVERRUN_EN
    logic        overrun;
`endif

    always #5 clk_operation = ~clk_operation;

    sig16b_to_double dut (
        .clk_operation          (clk_operation),
        .rst                    (rst),
        .sampling_cycle_counter (sampling_cycle_counter),
        .enable                 (enable),
        .sig16b                 (sig16b),
        .double                 (double),
        .double_valid           (double_valid),
        .busy                   (busy)
`ifdef SIG16B_TO_DOUBLE_OVERRUN_EN
        ,
        .overrun                (overrun)
`endif
    );

    typedef struct {
        logic [63:0] val;
        int          edge_n;
        logic [15:0] src;
    } exp_t;

    exp_t sb_q[$];
    int   edge_cnt    = 0;
    int   vectors     = 0;
    int   miscompares = 0;
    int   valid_cnt   = 0;
    logic valid_prev  = 1'b0;
    logic [63:0] last_exp = 64'h0;

    always @(posedge clk_operation) edge_cnt <= edge_cnt + 1;

    // Reference conversion built from integer arithmetic on the leading-one position.
    function automatic logic [63:0] model(input logic [15:0] s);
        logic [14:0] m;
        logic [51:0] mant;
        logic [10:0] e;
        int k;
        m = s[14:0];
        k = -1;
        for (int i = 0; i < 15; i++) if (m[i]) k = i;
        if (k < 0) return 64'h0;
        mant = 52'(m) << (52 - k);
        e    = 11'(1023 + k);
        return {s[15], e, mant};
    endfunction

    function automatic int latency(input logic [15:0] s);
        int k;
        k = -1;
        for (int i = 0; i < 15; i++) if (s[i]) k = i;
        return (k < 0) ? 1 : 15 - k;
    endfunction

    // Monitor: every valid pulse must match the head of the scoreboard in value and edge.
    initial forever begin
        exp_t e;
        @(negedge clk_operation);
        if (double_valid === 1'b1) begin
            valid_cnt++;
            vectors++;
            if (valid_prev === 1'b1) begin
                miscompares++;
                $display("FAIL valid_width: valid high on consecutive cycles at edge %0d, required single-cycle pulse", edge_cnt);
            end
            if (sb_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_valid: double=%h at edge %0d, required no pulse", double, edge_cnt);
            end else begin
                e = sb_q.pop_front();
                last_exp = e.val;
                vectors++;
                if (double !== e.val) begin
                    miscompares++;
                    $display("FAIL result(%h): got %h, required %h", e.src, double, e.val);
                end
                vectors++;
                if (edge_cnt !== e.edge_n) begin
                    miscompares++;
                    $display("FAIL latency(%h): valid at edge %0d, required edge %0d", e.src, edge_cnt, e.edge_n);
                end
            end
        end
        valid_prev = double_valid;
    end

    // Drive one capture slot; called at a negedge, returns at the negedge after capture edge t.
    task automatic capture(input logic [15:0] s, input bit expect_result, output int t);
        sampling_cycle_counter = 13'd0;
        enable = 1'b1;
        sig16b = s;
        t = edge_cnt + 1;
        if (expect_result) sb_q.push_back('{model(s), t + latency(s), s});
        @(negedge clk_operation);
        sampling_cycle_counter = 13'd7;
        enable = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((sb_q.size() != 0 || busy !== 1'b0) && n < 40) begin
            @(negedge clk_operation);
            n++;
        end
        vectors++;
        if (sb_q.size() != 0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL drain: pending=%0d busy=%b, required pending=0 busy=0", sb_q.size(), busy);
            sb_q.delete();
        end
        @(negedge clk_operation);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk_operation);
        vectors++;
        if (double !== 64'h0 || double_valid !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: double=%h valid=%b busy=%b, required 0 0 0", double, double_valid, busy);
        end
`ifdef SIG16B_TO_DOUBLE_OVERRUN_EN
        vectors++;
        if (overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_overrun: got %b, required 0", overrun);
        end
`endif
        rst = 1'b0;
        @(negedge clk_operation);
    endtask

    task automatic test_basic();
        logic [15:0] pats [6];
        int t, cyc;
        pats = '{16'h0001, 16'h7FFF, 16'h8003, 16'h8000, 16'h0000, 16'h4000};
        foreach (pats[i]) begin
            capture(pats[i], 1'b1, t);
            cyc = 0;
            while (busy === 1'b1 && cyc < 40) begin
                cyc++;
                @(negedge clk_operation);
            end
            vectors++;
            if (cyc != latency(pats[i])) begin
                miscompares++;
                $display("FAIL busy_cycles(%h): got %0d, required %0d", pats[i], cyc, latency(pats[i]));
            end
            wait_drain();
        end
    endtask

    task automatic test_qualifiers();
        sampling_cycle_counter = 13'd0;
        enable = 1'b0;
        sig16b = 16'h1234;
        @(negedge clk_operation);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL no_enable: busy=%b, required 0", busy);
        end
        sampling_cycle_counter = 13'd1;
        enable = 1'b1;
        @(negedge clk_operation);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL counter_nonzero: busy=%b, required 0", busy);
        end
        sampling_cycle_counter = 13'd7;
        enable = 1'b0;
        @(negedge clk_operation);
    endtask

    task automatic test_reset_abort();
        int t, vc;
        capture(16'h0001, 1'b0, t);
        while (edge_cnt < t + 4) @(negedge clk_operation);
        vc = valid_cnt;
        rst = 1'b1;
        @(negedge clk_operation);
        vectors++;
        if (busy !== 1'b0 || double !== 64'h0) begin
            miscompares++;
            $display("FAIL abort_state: busy=%b double=%h, required 0 0", busy, double);
        end
        rst = 1'b0;
        repeat (16) @(negedge clk_operation);
        vectors++;
        if (valid_cnt != vc) begin
            miscompares++;
            $display("FAIL abort_no_valid: %0d pulses, required 0", valid_cnt - vc);
        end
        // Reset must win over a simultaneous capture request.
        rst = 1'b1;
        sampling_cycle_counter = 13'd0;
        enable = 1'b1;
        sig16b = 16'h4000;
        @(negedge clk_operation);
        rst = 1'b0;
        sampling_cycle_counter = 13'd7;
        enable = 1'b0;
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_priority: busy=%b, required 0", busy);
        end
        capture(16'h0023, 1'b1, t);
        wait_drain();
    endtask

    task automatic test_capture_busy();
        int t;
        capture(16'h0001, 1'b1, t);
        while (edge_cnt < t + 2) @(negedge clk_operation);
        sampling_cycle_counter = 13'd0;
        enable = 1'b1;
        sig16b = 16'h7FFF;
        @(negedge clk_operation);
        sampling_cycle_counter = 13'd7;
        enable = 1'b0;
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL busy_during_capture: busy=%b, required 1", busy);
        end
`ifdef SIG16B_TO_DOUBLE_OVERRUN_EN
        vectors++;
        if (overrun !== 1'b1) begin
            miscompares++;
            $display("FAIL overrun_set: got %b, required 1", overrun);
        end
`endif
        wait_drain();
`ifdef SIG16B_TO_DOUBLE_OVERRUN_EN
        vectors++;
        if (overrun !== 1'b1) begin
            miscompares++;
            $display("FAIL overrun_sticky: got %b, required 1", overrun);
        end
        rst = 1'b1;
        @(negedge clk_operation);
        rst = 1'b0;
        vectors++;
        if (overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL overrun_clear: got %b, required 0", overrun);
        end
`endif
    endtask

    task automatic test_back_to_back();
        int t, n;
        logic [15:0] s;
        for (int i = 0; i < 12; i++) begin
            s = 16'($urandom);
            if (i % 3 == 1) s = s & 16'h801F;
            capture(s, 1'b1, t);
            n = 0;
            while (busy === 1'b1 && n < 40) begin
                @(negedge clk_operation);
                n++;
            end
        end
        wait_drain();
        repeat (3) @(negedge clk_operation);
        vectors++;
        if (double !== last_exp) begin
            miscompares++;
            $display("FAIL hold: got %h, required %h", double, last_exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        @(negedge clk_operation);
        test_reset();
        test_basic();
        test_qualifiers();
        test_reset_abort();
        test_capture_busy();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sig16b_to_double.md
SIG16B_TO_DOUBLE -- requirements
Module: sig16b_to_double

Interface
REQ-001 SHALL have port clk_operation  input  1  operation clock; all state changes on its rising edge.
REQ-002 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-003 SHALL have port sampling_cycle_counter  input  13  sample-period phase; 0 marks the capture slot.
REQ-004 SHALL have port enable  input  1  capture qualifier.
REQ-005 SHALL have port sig16b  input  16  sample, sign-magnitude: [15] sign, [14:0] integer magnitude.
REQ-006 SHALL have port double  output  64  IEEE-754 binary64 equal to the sample value.
REQ-007 SHALL have port double_valid  output  1  one-cycle pulse when double is updated.
REQ-008 SHALL have port busy  output  1  high while a conversion is in progress.
REQ-009 SHALL have port overrun  output  1  sticky dropped-capture flag, present only under SIG16B_TO_DOUBLE_OVERRUN_EN.

Function
REQ-010 SHALL capture sig16b on an edge where sampling_cycle_counter==0, enable==1, rst==0 and state is IDLE.
- Capture loads sign_r, mag_r=sig16b[14:0], exp_r=1037; next state NORM.
REQ-011 SHALL implement states IDLE, NORM.
- busy = (state==NORM).
REQ-012 On each NORM edge, SHALL apply the first matching rule:
- mag_r==0: write double=64'h0 (sign dropped, -0 becomes +0); pulse double_valid; go to IDLE.
- mag_r[14]==1: write double = {sign_r, exp_r[10:0], mag_r[13:0], 38'b0}; pulse double_valid; go to IDLE.
- Otherwise: mag_r <= mag_r<<1; exp_r <= exp_r-1; stay in NORM.
REQ-013 Latency SHALL be exact for capture at edge T and leading one at bit k:
- double and double_valid are updated at edge T+1+(14-k), so the maximum is T+15.
- For zero input, the update is at edge T+1.
REQ-014 double SHALL hold its last value between conversions.
- double_valid SHALL be high for exactly one cycle per conversion.
REQ-015 A capture condition arriving while busy SHALL be ignored; the conversion in progress is unaffected.
REQ-016 Conversion SHALL be exact: every 15-bit magnitude is representable, so no rounding occurs.
- The exponent stays within 1023..1037.

Reset
REQ-017 rst SHALL act on any edge, independent of sampling_cycle_counter.
- Reset values: state IDLE, double=0, double_valid=0, busy=0, overrun=0, internal registers 0.
REQ-018 rst during NORM SHALL abort the conversion with no double_valid pulse.
- rst SHALL take priority over a simultaneous capture condition.

Configuration
REQ-019 Macro SIG16B_TO_DOUBLE_OVERRUN_EN defined: the overrun port and logic SHALL exist.
- overrun sets when a capture condition occurs while busy.
- overrun clears only on rst.
REQ-020 Macro SIG16B_TO_DOUBLE_OVERRUN_EN undefined: the overrun port and logic SHALL be absent; all other behaviour is identical.

Structure
REQ-021 Shared package SHALL hold the following:
- DOUBLE_BIAS=1023
- EXP_INIT=1037
- SIG16B_W=16
- DOUBLE_W=64
- MANT_W=52
- state enum {IDLE, NORM}
REQ-022 SHALL be a single module with no sub-module; normalization is the iterative shift FSM.

Verification
REQ-023 Sample 0x0001, capture at T -> double=0x3FF0_0000_0000_0000 at edge T+15, valid pulse 1 cycle, busy high for 15 cycles.
REQ-024 Sample 0x7FFF -> double=0x40DF_FFC0_0000_0000 at edge T+1.
REQ-025 Sample 0x8003 -> double=0xC008_0000_0000_0000 at edge T+14.
REQ-026 Sample 0x8000, then 0x0000 -> double=0x0 at edge T+1 in both cases.
REQ-027 Sample 0x0001, rst asserted at T+5 -> no valid pulse, double=0, IDLE.
- Next capture converts normally.
REQ-028 Capture while busy (counter forced to 0 at T+3) -> ignored; original result delivered at T+15.
- overrun=1 with the macro defined; no overrun port without it.
